// File: rtl/lfsr_word_arbiter.sv
// Round-robin distributor of words from a shared free-running LFSR. A word is
// handed out only after MIN_SHIFTS fresh shifts since the previous hand-out.
module lfsr_word_arbiter #(
    parameter int WIDTH      = 16,
    parameter int NREQ       = 4,
    parameter int MIN_SHIFTS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lfsr_value,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);
    localparam int CW = $clog2(MIN_SHIFTS + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_SHIFTS);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ready_q, ready_d;

    logic [NREQ-1:0]  above_ptr;
    logic [NREQ-1:0]  req_above;
    logic [PW-1:0]    win_idx;
    logic             decide;

    function automatic logic [PW-1:0] lowest_set(input logic [NREQ-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    // Requests strictly above the last winner get first pick; otherwise wrap to the bottom.
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            above_ptr[i] = (i > int'(rr_ptr_q));
        end
        req_above = req & above_ptr;
        win_idx   = (|req_above) ? lowest_set(req_above) : lowest_set(req);
        decide    = (cnt_q == CNT_MAX) && (|req);
    end

    always_comb begin
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = '0;
        valid_d  = 1'b0;
        data_d   = data_q;
        if (decide) begin
            cnt_d    = CW'(1);
            rr_ptr_d = win_idx;
            grant_d  = NREQ'(1) << win_idx;
            valid_d  = 1'b1;
            data_d   = lfsr_value;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        ready_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rr_ptr_q <= PTR_RST;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
        end
    end

    assign grant = grant_q;
    assign valid = valid_q;
    assign data  = data_q;
    assign ready = ready_q;
endmodule

// File: doc/lfsr_word_arbiter.md
Name: lfsr_word_arbiter

Overview:
- Shares one free-running entropy LFSR between up to NREQ consumers. Each consumer gets a full random word.
- Enforces freshness: each delivered word contains at least MIN_SHIFTS new shifted-in bits since the previous delivery, so no two consumers see correlated words.
- Sits between the LFSR output bus and the consumer blocks. Uses round-robin arbitration with single-cycle grant pulses.

Parameters:
- WIDTH, 16: width of lfsr_value and data.
- NREQ, 4: number of requesters. Legal range 1..16.
- MIN_SHIFTS, 16: minimum clock edges (LFSR shifts) between successive samples. Must be >= 1.

Ports:
- clk  input  1  system clock; the LFSR shifts on every rising edge.
- rst  input  1  synchronous, active-high reset.
- lfsr_value  input  WIDTH  current LFSR shift register contents.
- req  input  NREQ  level request per consumer; held until granted.
- grant  output  NREQ  one-hot, one-cycle pulse marking which consumer owns data this cycle.
- valid  output  1  high exactly when grant != 0.
- data  output  WIDTH  sampled random word; holds its value between deliveries.
- ready  output  1  freshness met (cnt == MIN_SHIFTS); a decision is possible at the next edge.

Behaviour:
- All outputs are registered.
- State on reset (rst high at an edge): grant=0, valid=0, data=0, cnt=0, rr_ptr=NREQ-1 (requester 0 has highest priority first).
- cnt width: clog2(MIN_SHIFTS+1). cnt update at each edge with rst low:
  - loads 1 if a grant decision is taken at that edge;
  - else increments if cnt < MIN_SHIFTS;
  - else saturates at MIN_SHIFTS.
- Decision condition: cnt == MIN_SHIFTS and req != 0. At that edge:
  - winner = first set req bit scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ (wrap NREQ-1 -> 0);
  - grant <= onehot(winner), valid <= 1, data <= lfsr_value sampled at that edge, rr_ptr <= winner.
- No decision at an edge: grant <= 0, valid <= 0; data and rr_ptr hold.
- Latency:
  - from ready=1 with a req present: grant visible 1 cycle later;
  - after reset release with req held: first grant visible after MIN_SHIFTS+1 edges. This warm-up also covers the LFSR's own init cycle.
- Grant spacing: exactly MIN_SHIFTS cycles between grant pulses under continuous requests. For MIN_SHIFTS=1 this is a grant every cycle.
- Requests are level-sensitive and not latched. A req dropped before its grant is not served.
- A requester holding req across its own grant is re-queued behind the others by round-robin.
- Consumer must capture data in the cycle grant[i]=1. data is stable until the next valid.
- Simultaneous events:
  - req changing in the decision edge's cycle: the sampled value at that edge is used;
  - rst together with a decision condition: reset wins, no grant.
- Reset mid-operation: a pending or active grant is dropped; valid=0 the following cycle; warm-up restarts from cnt=0; priority restarts at requester 0.
- NREQ=1: the arbiter degenerates to a rate limiter; grant[0]=valid.
- Invariants: grant is one-hot or zero; valid == |grant; no grant while ready was 0 at the decision edge.

Test Plan:
- Setup WIDTH=16, NREQ=4, MIN_SHIFTS=16; rst high 3 cycles then low; req=4'b0001 held. Required: first grant=4'b0001 at the 17th edge after rst release; data equals lfsr_value at that edge; the next grant follows exactly 16 cycles later.
- req=4'b1111 held after warm-up. Required: grant sequence 0001, 0010, 0100, 1000, 0001, spaced 16 cycles; valid high only on those cycles; data constant between them.
- req=4'b1010 held. Required: grants alternate 0010, 1000, 0010, i.e. requester 3 wraps to 1 with no skipped slot.
- req=0 until cnt saturates (ready=1 for 40 cycles), then req=4'b0100 for a single cycle. Required: grant=0100 one cycle later; cnt reloads 1; ready drops for 15 cycles. In a separate run, req pulsed while ready=0 and dropped before ready: no grant.
- rst asserted for 1 cycle on the cycle grant=0010 is visible, with req=4'b1111 held. Required: grant=0 and valid=0 next cycle, data=0; next grant=0001 at the 17th edge after rst release.
- MIN_SHIFTS=1, req=4'b1111. Required: a grant every cycle rotating 0001, 0010, 0100, 1000; each data equals lfsr_value from the preceding edge.
